// File: rtl/cim_pkg.sv
// Shared constants, FSM state type and index-width helpers for the parametrised GeMM CIM macro.
package cim_pkg;

   localparam int unsigned W_BITS     = 8;
   localparam int unsigned WORD_BITS  = 32;
   localparam int unsigned BYTE_SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      WB
   } state_e;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cim_lane_mac.sv
// One column's bit-serial accumulator: sums the weights of rows whose input bit is set,
// shifts by the bit position, and subtracts the slice on the sign bit.
module cim_lane_mac
   import cim_pkg::*;
#(
   parameter int unsigned ROWS  = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned BIT_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic                     msb_i,
   input  logic [BIT_W-1:0]         bit_idx_i,
   input  logic [ROWS*W_BITS-1:0]   weights_i,
   input  logic [ROWS-1:0]          x_bits_i,
   output logic [AW-1:0]            acc_o
);

   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] slice_c;
   logic [AW-1:0] term_c;

   always_comb begin
      slice_c = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
         if (x_bits_i[r]) begin
            slice_c = slice_c + AW'($signed(weights_i[r*W_BITS +: W_BITS]));
         end
      end
      term_c = slice_c << bit_idx_i;
      acc_d  = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = msb_i ? (acc_q - term_c) : (acc_q + term_c);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/param_gemm_cim.sv
// Parametrised GeMM compute-in-memory macro: weight store, bit-serial lane MACs and output register bank.
// Optional build macro CIM_ACC_SAT_EN: saturating writeback with 2-bit-wider lane accumulators.
module param_gemm_cim
   import cim_pkg::*;
#(
   parameter int unsigned ROWS     = 4,
   parameter int unsigned COLS     = 128,
   parameter int unsigned IN_BITS  = 8,
   parameter int unsigned LANES    = 4,
   parameter int unsigned NUM_OREG = 16,
   parameter int unsigned ACC_W    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cs,
   input  logic                         web,
   input  logic [31:0]                  address,
   input  logic [31:0]                  input_data,
   input  logic                         start,
   input  logic                         partial_sum_eb,
   input  logic [$clog2(NUM_OREG)-1:0]  output_reg,
   input  logic                         reset_output_reg,
   output logic                         busy,
   output logic                         done,
   output logic [31:0]                  mem_output,
   output logic [ACC_W-1:0]             cim_output
);

   localparam int unsigned COL_W  = $clog2(COLS);
   localparam int unsigned ROW_W  = idx_w(ROWS);
   localparam int unsigned WORD_W = COL_W - BYTE_SEL_W;
   localparam int unsigned NWORDS = COLS / 4;
   localparam int unsigned OREG_W = $clog2(NUM_OREG);
   localparam int unsigned BIT_W  = idx_w(IN_BITS);
   localparam int unsigned X_W    = ROWS * IN_BITS;
`ifdef CIM_ACC_SAT_EN
   localparam int unsigned AW     = ACC_W + 2;
`else
   localparam int unsigned AW     = ACC_W;
`endif

   logic [WORD_BITS-1:0] weight_mem [ROWS][NWORDS];

   state_e              state_q, state_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [OREG_W-1:0]   base_q, base_d;
   logic                psum_q, psum_d;
   logic [31:0]         mem_output_q, mem_output_d;
   logic [ACC_W-1:0]    cim_output_q, cim_output_d;
   logic [ACC_W-1:0]    oreg_q [NUM_OREG];
   logic [ACC_W-1:0]    oreg_d [NUM_OREG];

   logic [ROW_W-1:0]    row_c;
   logic [WORD_W-1:0]   word_c;
   logic                wr_en_c, rd_en_c, start_ok_c;
   logic                lane_clr_c, lane_en_c, msb_c;
   logic [ROWS-1:0]     x_bits_c;
   logic [OREG_W-1:0]   wb_idx_c;
   logic [ACC_W-1:0]    wb_old_c;
   logic [ROWS*W_BITS-1:0] lane_w_c [LANES];
   logic [AW-1:0]       lane_acc [LANES];
   logic                unused_addr_c;

   assign row_c         = address[COL_W +: ROW_W];
   assign word_c        = address[BYTE_SEL_W +: WORD_W];
   assign unused_addr_c = ^{address[31:COL_W+ROW_W], address[BYTE_SEL_W-1:0]};

   // A write in the same cycle as start takes priority and suppresses the start.
   assign wr_en_c    = cs & web & ~busy_q;
   assign rd_en_c    = cs & ~web & ~busy_q;
   assign start_ok_c = start & ~busy_q & ~(cs & web);
   assign msb_c      = (bit_q == BIT_W'(IN_BITS - 1));

   function automatic logic [ACC_W-1:0] wb_value(input logic [ACC_W-1:0] old,
                                                 input logic [AW-1:0]    acc);
`ifdef CIM_ACC_SAT_EN
      logic [AW-1:0] sum;
      sum = AW'($signed(old)) + acc;
      if ((&sum[AW-1:ACC_W-1]) || ~(|sum[AW-1:ACC_W-1])) begin
         return sum[ACC_W-1:0];
      end
      return sum[AW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
      return old + acc;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         weight_mem[row_c][word_c] <= input_data;
      end
   end

   // Lane l sees byte l of the latched column word from every row.
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         lane_w_c[l] = '0;
         for (int r = 0; r < int'(ROWS); r++) begin
            lane_w_c[l][r*W_BITS +: W_BITS] = weight_mem[r][word_q][l*W_BITS +: W_BITS];
         end
      end
   end

   // x_q shifts right once per compute cycle, so each row's current bit sits at its slot base.
   always_comb begin
      x_bits_c = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
         x_bits_c[r] = x_q[r*IN_BITS];
      end
   end

   for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
      cim_lane_mac #(
         .ROWS  (ROWS),
         .AW    (AW),
         .BIT_W (BIT_W)
      ) u_mac (
         .clk       (clk),
         .rst       (rst),
         .clr_i     (lane_clr_c),
         .en_i      (lane_en_c),
         .msb_i     (msb_c),
         .bit_idx_i (bit_q),
         .weights_i (lane_w_c[l]),
         .x_bits_i  (x_bits_c),
         .acc_o     (lane_acc[l])
      );
   end

   always_comb begin
      state_d      = state_q;
      bit_d        = bit_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      x_d          = x_q;
      word_d       = word_q;
      base_d       = base_q;
      psum_d       = psum_q;
      lane_clr_c   = 1'b0;
      lane_en_c    = 1'b0;
      wb_idx_c     = '0;
      wb_old_c     = '0;
      oreg_d       = oreg_q;
      mem_output_d = rd_en_c ? weight_mem[row_c][word_c] : mem_output_q;
      cim_output_d = oreg_q[output_reg];

      if (reset_output_reg) begin
         for (int i = 0; i < int'(NUM_OREG); i++) begin
            oreg_d[i] = '0;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_ok_c) begin
               x_d        = input_data[X_W-1:0];
               word_d     = word_c;
               base_d     = output_reg;
               psum_d     = partial_sum_eb;
               bit_d      = '0;
               lane_clr_c = 1'b1;
               busy_d     = 1'b1;
               state_d    = COMPUTE;
            end
         end
         COMPUTE: begin
            lane_en_c = 1'b1;
            x_d       = x_q >> 1;
            if (msb_c) begin
               state_d = WB;
            end else begin
               bit_d = bit_q + BIT_W'(1);
            end
         end
         WB: begin
            // A coincident clear wins over the old contents, so accumulate lands on zero.
            for (int l = 0; l < int'(LANES); l++) begin
               wb_idx_c         = base_q + OREG_W'(l);
               wb_old_c         = (reset_output_reg || !psum_q) ? '0 : oreg_q[wb_idx_c];
               oreg_d[wb_idx_c] = wb_value(wb_old_c, lane_acc[l]);
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         x_q          <= '0;
         word_q       <= '0;
         base_q       <= '0;
         psum_q       <= 1'b0;
         mem_output_q <= '0;
         cim_output_q <= '0;
         for (int i = 0; i < int'(NUM_OREG); i++) begin
            oreg_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         bit_q        <= bit_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         x_q          <= x_d;
         word_q       <= word_d;
         base_q       <= base_d;
         psum_q       <= psum_d;
         mem_output_q <= mem_output_d;
         cim_output_q <= cim_output_d;
         oreg_q       <= oreg_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign mem_output = mem_output_q;
   assign cim_output = cim_output_q;

endmodule

// File: tb/tb_param_gemm_cim.sv
// Directed, table-driven bench for param_gemm_cim with hand-computed expected values.
module tb_param_gemm_cim;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic        web;
   logic [31:0] address;
   logic [31:0] input_data;
   logic        start;
   logic        partial_sum_eb;
   logic [3:0]  output_reg;
   logic        reset_output_reg;
   logic        busy;
   logic        done;
   logic [31:0] mem_output;
   logic [31:0] cim_output;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } mem_vec_t;

   typedef struct {
      logic [31:0]      x;
      int               base;
      logic             psum;
      logic [3:0][31:0] exp;
   } job_t;

   mem_vec_t wr_tab [4];
   mem_vec_t rd_tab [6];
   job_t     jobs   [3];

   param_gemm_cim dut (
      .clk              (clk),
      .rst              (rst),
      .cs               (cs),
      .web              (web),
      .address          (address),
      .input_data       (input_data),
      .start            (start),
      .partial_sum_eb   (partial_sum_eb),
      .output_reg       (output_reg),
      .reset_output_reg (reset_output_reg),
      .busy             (busy),
      .done             (done),
      .mem_output       (mem_output),
      .cim_output       (cim_output)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_oreg(input int idx, input logic [31:0] exp, input string tag);
      output_reg = 4'(idx);
      tick();
      check($sformatf("%s_oreg%0d", tag, idx), cim_output, exp);
   endtask

   task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
      cs = 1'b1; web = 1'b1; address = a; input_data = d;
      tick();
      cs = 1'b0; web = 1'b0;
   endtask

   task automatic mem_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
      cs = 1'b1; web = 1'b0; address = a;
      tick();
      cs = 1'b0;
      check(tag, mem_output, exp);
   endtask

   task automatic run_job(input logic [31:0] x, input int base, input logic psum, input string tag);
      int lat;
      lat = -1;
      input_data = x; output_reg = 4'(base); partial_sum_eb = psum; address = 32'h0;
      start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         start = 1'b0;
         if (n == 1) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
         if (done) begin
            lat = n;
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'd10);
      tick();
      check({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
   endtask

   initial begin
      int  lat;
      bit  done_seen;

      wr_tab[0] = '{32'd0,   32'h03020100};
      wr_tab[1] = '{32'd128, 32'h07060504};
      wr_tab[2] = '{32'd256, 32'h0b0a0908};
      wr_tab[3] = '{32'd384, 32'h0f0e0d0c};
      rd_tab[0] = '{32'd256, 32'h0b0a0908};
      rd_tab[1] = '{32'd0,   32'h03020100};
      rd_tab[2] = '{32'd384, 32'h0f0e0d0c};
      rd_tab[3] = '{32'd258, 32'h0b0a0908};  // byte offset ignored
      rd_tab[4] = '{32'd640, 32'h07060504};  // row index wraps to 1
      rd_tab[5] = '{32'd128, 32'h07060504};
      jobs[0] = '{32'h88888888, 0,  1'b0, {32'(-4320), 32'(-3840), 32'(-3360), 32'(-2880)}};
      jobs[1] = '{32'h01010101, 0,  1'b1, {32'(-4284), 32'(-3808), 32'(-3332), 32'(-2856)}};
      jobs[2] = '{32'h01010101, 14, 1'b0, {32'd36, 32'd32, 32'd28, 32'd24}};

      rst = 1'b1; cs = 1'b0; web = 1'b0; address = '0; input_data = '0;
      start = 1'b0; partial_sum_eb = 1'b0; output_reg = '0; reset_output_reg = 1'b0;
      tick();
      tick();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_mem_output", mem_output, 32'd0);
      check("reset_cim_output", cim_output, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) mem_write(wr_tab[i].addr, wr_tab[i].data);
      for (int i = 0; i < 6; i++) mem_read(rd_tab[i].addr, rd_tab[i].data, $sformatf("read%0d", i));

      for (int j = 0; j < 3; j++) begin
         run_job(jobs[j].x, jobs[j].base, jobs[j].psum, $sformatf("job%0d", j));
         for (int l = 0; l < 4; l++)
            check_oreg((jobs[j].base + l) % 16, jobs[j].exp[l], $sformatf("job%0d", j));
      end
      check_oreg(2, 32'(-3808), "wrap_untouched");
      check_oreg(3, 32'(-4284), "wrap_untouched");

      // Busy window: write, read and start are ignored; clear coincides with WB.
      mem_read(32'd384, 32'h0f0e0d0c, "pre_busy_read");
      lat = -1;
      input_data = 32'h01010101; output_reg = 4'd8; partial_sum_eb = 1'b0; address = 32'h0;
      start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n == 1) start = 1'b0;
         if (n == 2) begin cs = 1'b1; web = 1'b1; address = 32'h0; input_data = 32'hffffffff; end
         if (n == 3) begin web = 1'b0; address = 32'd256; end
         if (n == 4) begin cs = 1'b0; start = 1'b1; output_reg = 4'd4; end
         if (n == 5) start = 1'b0;
         if (n == 9) reset_output_reg = 1'b1;
         if (n == 10) reset_output_reg = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      reset_output_reg = 1'b0;
      check("busy_latency", 32'(lat), 32'd10);
      check("busy_read_ignored", mem_output, 32'h0f0e0d0c);
      check_oreg(8,  32'd24, "wbclr");
      check_oreg(9,  32'd28, "wbclr");
      check_oreg(10, 32'd32, "wbclr");
      check_oreg(11, 32'd36, "wbclr");
      check_oreg(0,  32'd0,  "wbclr");
      check_oreg(1,  32'd0,  "wbclr");
      check_oreg(3,  32'd0,  "wbclr");
      check_oreg(14, 32'd0,  "wbclr");
      check_oreg(15, 32'd0,  "wbclr");
      check("busy_start_ignored", 32'(busy), 32'd0);
      mem_read(32'd0, 32'h03020100, "busy_write_dropped");

      // Write and start in the same cycle: write wins.
      cs = 1'b1; web = 1'b1; address = 32'd132; input_data = 32'h11223344; start = 1'b1;
      tick();
      cs = 1'b0; web = 1'b0; start = 1'b0;
      check("wr_start_busy", 32'(busy), 32'd0);
      tick();
      check("wr_start_busy2", 32'(busy), 32'd0);
      mem_read(32'd132, 32'h11223344, "wr_start_data");

      // Reset mid-compute: no writeback, no done, weights retained.
      reset_output_reg = 1'b1;
      tick();
      reset_output_reg = 1'b0;
      check_oreg(8, 32'd0, "clr");
      input_data = 32'h01010101; output_reg = 4'd0; partial_sum_eb = 1'b0; address = 32'h0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_mem_output", mem_output, 32'd0);
      done_seen = 1'b0;
      for (int n = 0; n < 15; n++) begin
         tick();
         if (done) done_seen = 1'b1;
      end
      check("rst_mid_no_done", 32'(done_seen), 32'd0);
      for (int l = 0; l < 4; l++) check_oreg(l, 32'd0, "rst_mid");
      mem_read(32'd0, 32'h03020100, "rst_weights_kept");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
